// File: rtl/smbm_ctrl.sv
// Round-robin command scheduler in front of one smbm buffer. Rejects illegal commands
// locally, tracks occupancy, sequences the smbm reset and recovers from a hung done.
module smbm_ctrl #(
   parameter int unsigned NUM_REQ            = 4,
   parameter int unsigned BIT_VEC_SIZE       = 128,
   parameter int unsigned BIT_VEC_SIZE_LOG   = 7,
   parameter int unsigned NUM_OF_METRICS     = 8,
   parameter int unsigned NUM_OF_METRICS_LOG = 3,
   parameter int unsigned TIMEOUT            = 15
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_REQ-1:0]                    req_valid,
   output logic [NUM_REQ-1:0]                    req_ready,
   input  logic [NUM_REQ*2-1:0]                  req_op,
   input  logic [NUM_REQ*BIT_VEC_SIZE_LOG-1:0]   req_id,
   input  logic [NUM_REQ*NUM_OF_METRICS*8-1:0]   req_metric,
   input  logic [NUM_REQ*BIT_VEC_SIZE-1:0]       req_mask,
   input  logic [NUM_REQ*NUM_OF_METRICS_LOG-1:0] req_metric_sel,
   input  logic [NUM_REQ*3-1:0]                  req_rmode,
   output logic                                  rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]            rsp_req,
   output logic [2:0]                            rsp_status,
   output logic                                  sm_rst,
   output logic [2:0]                            sm_opcode,
   output logic [BIT_VEC_SIZE_LOG-1:0]           sm_id,
   output logic [NUM_OF_METRICS*8-1:0]           sm_metric_val,
   output logic [BIT_VEC_SIZE-1:0]               sm_in,
   output logic [NUM_OF_METRICS_LOG-1:0]         sm_metricX,
   output logic [2:0]                            sm_opcode_in,
   input  logic                                  sm_done,
   output logic [BIT_VEC_SIZE_LOG:0]             count,
   output logic                                  full,
   output logic                                  empty
);

   localparam int unsigned RW = $clog2(NUM_REQ);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned CW = BIT_VEC_SIZE_LOG + 1;

   localparam logic [1:0] OpAdd = 2'b00;
   localparam logic [1:0] OpDel = 2'b01;
   localparam logic [1:0] OpBad = 2'b11;

   localparam logic [2:0] StatOk      = 3'b000;
   localparam logic [2:0] StatFull    = 3'b001;
   localparam logic [2:0] StatDup     = 3'b010;
   localparam logic [2:0] StatAbsent  = 3'b011;
   localparam logic [2:0] StatTimeout = 3'b100;
   localparam logic [2:0] StatBadOp   = 3'b101;

   typedef enum logic [2:0] {StInit, StIdle, StIssue, StWait, StResp} state_e;

   state_e                          state_q, state_d;
   logic                            init_cnt_q, init_cnt_d;
   logic [TW-1:0]                   wait_cnt_q, wait_cnt_d;
   logic [RW-1:0]                   rr_ptr_q, rr_ptr_d;
   logic [BIT_VEC_SIZE-1:0]         bitmap_q, bitmap_d;
   logic [CW-1:0]                   count_q, count_d;
   logic [2:0]                      status_q, status_d;
   logic [RW-1:0]                   req_q;
   logic [1:0]                      op_q;
   logic [BIT_VEC_SIZE_LOG-1:0]     id_q;
   logic [NUM_OF_METRICS*8-1:0]     metric_q;
   logic [BIT_VEC_SIZE-1:0]         mask_q;
   logic [NUM_OF_METRICS_LOG-1:0]   msel_q;
   logic [2:0]                      rmode_q;

   logic                            found;
   logic                            grant;
   logic [RW-1:0]                   win;
   int unsigned                     win_i;
   logic [1:0]                      win_op;
   logic [BIT_VEC_SIZE_LOG-1:0]     win_id;

   // First valid requester at or after rr_ptr wins.
   always_comb begin
      found = 1'b0;
      win   = rr_ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[rr_ptr_q + RW'(i)]) begin
            found = 1'b1;
            win   = rr_ptr_q + RW'(i);
         end
      end
   end

   assign grant  = (state_q == StIdle) && found;
   assign win_i  = 32'(win);
   assign win_op = req_op[win_i*2 +: 2];
   assign win_id = req_id[win_i*BIT_VEC_SIZE_LOG +: BIT_VEC_SIZE_LOG];

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[win] = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = 1'b0;
      wait_cnt_d = '0;
      rr_ptr_d   = rr_ptr_q;
      bitmap_d   = bitmap_q;
      count_d    = count_q;
      status_d   = status_q;
      unique case (state_q)
         StInit: begin
            bitmap_d   = '0;
            count_d    = '0;
            init_cnt_d = 1'b1;
            if (init_cnt_q) state_d = StIdle;
         end
         StIdle: begin
            if (found) begin
               rr_ptr_d = win + RW'(1);
               state_d  = StResp;
               if (win_op == OpBad)                            status_d = StatBadOp;
               else if (win_op == OpAdd && full)               status_d = StatFull;
               else if (win_op == OpAdd && bitmap_q[win_id])   status_d = StatDup;
               else if (win_op == OpDel && !bitmap_q[win_id])  status_d = StatAbsent;
               else                                            state_d  = StIssue;
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (sm_done) begin
               state_d  = StResp;
               status_d = StatOk;
            end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
               state_d  = StResp;
               status_d = StatTimeout;
            end else begin
               wait_cnt_d = wait_cnt_q + TW'(1);
            end
         end
         StResp: begin
            if (status_q == StatTimeout) begin
               state_d = StInit;
            end else begin
               state_d = StIdle;
               if (status_q == StatOk && op_q == OpAdd) begin
                  bitmap_d[id_q] = 1'b1;
                  count_d        = count_q + CW'(1);
               end else if (status_q == StatOk && op_q == OpDel) begin
                  bitmap_d[id_q] = 1'b0;
                  count_d        = count_q - CW'(1);
               end
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StInit;
         init_cnt_q <= 1'b0;
         wait_cnt_q <= '0;
         rr_ptr_q   <= '0;
         bitmap_q   <= '0;
         count_q    <= '0;
         status_q   <= StatOk;
         req_q      <= '0;
         op_q       <= '0;
         id_q       <= '0;
         metric_q   <= '0;
         mask_q     <= '0;
         msel_q     <= '0;
         rmode_q    <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         bitmap_q   <= bitmap_d;
         count_q    <= count_d;
         status_q   <= status_d;
         if (grant) begin
            req_q    <= win;
            op_q     <= win_op;
            id_q     <= win_id;
            metric_q <= req_metric[win_i*NUM_OF_METRICS*8 +: NUM_OF_METRICS*8];
            mask_q   <= req_mask[win_i*BIT_VEC_SIZE +: BIT_VEC_SIZE];
            msel_q   <= req_metric_sel[win_i*NUM_OF_METRICS_LOG +: NUM_OF_METRICS_LOG];
            rmode_q  <= req_rmode[win_i*3 +: 3];
         end
      end
   end

   assign rsp_valid     = (state_q == StResp);
   assign rsp_req       = req_q;
   assign rsp_status    = status_q;
   assign sm_rst        = (state_q == StInit);
   assign sm_opcode     = (state_q == StIssue) ? {1'b0, op_q} : 3'b111;
   assign sm_id         = id_q;
   assign sm_metric_val = metric_q;
   assign sm_in         = mask_q;
   assign sm_metricX    = msel_q;
   assign sm_opcode_in  = rmode_q;
   assign count         = count_q;
   assign full          = (count_q == CW'(BIT_VEC_SIZE));
   assign empty         = (count_q == '0);

endmodule
